// File: rtl/temporizador_es.sv
// temporizador_es: programmable 8-bit interval timer on a CPU device port pair.
// Commands arrive on a strobe-less byte. A change of bit 7 against the stored
// toggle bit marks a new command. Status or the live count is read back, and
// a single interrupt request line is driven from registered state.
module temporizador_es #(
  parameter int PRESCALER = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] datoCPU,
  output logic [7:0] datoDispositivo,
  output logic       interrupcion
);

  // Prescaler width is ceil(log2(PRESCALER)), never below one bit.
  localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALER - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD_LO = 2'b00,
    CMD_LOAD_HI = 2'b01,
    CMD_CONTROL = 2'b10,
    CMD_ACK     = 2'b11
  } cmd_t;

  // Architectural state
  state_t        state;
  logic          toggle_reg;
  logic          pendiente;
  logic          periodic;
  logic          irq_en;
  logic          view;
  logic [7:0]    recarga;
  logic [7:0]    contador;
  logic [PW-1:0] presc;

  // Command decode
  cmd_t       cmd;
  logic [3:0] arg;
  logic       accept;
  logic       is_load_lo;
  logic       is_load_hi;
  logic       is_control;
  logic       is_ack;
  logic       ctl_disable;
  logic       restart;
  logic       tick;
  logic       expire;

  // Bit 4 of the argument has no meaning for any command.
  logic unused_arg4;
  assign unused_arg4 = datoCPU[4];

  assign cmd    = cmd_t'(datoCPU[6:5]);
  assign arg    = datoCPU[3:0];
  assign accept = (datoCPU[7] != toggle_reg);

  assign is_load_lo = accept && (cmd == CMD_LOAD_LO);
  assign is_load_hi = accept && (cmd == CMD_LOAD_HI);
  assign is_control = accept && (cmd == CMD_CONTROL);
  assign is_ack     = accept && (cmd == CMD_ACK);

  // A disable always wins over a tick on the same edge.
  assign ctl_disable = is_control && !arg[0];

  // Enable from a stopped state, or ACK-with-rearm from any non-idle state,
  // restarts the interval from the reload value.
  assign restart = (is_control && arg[0] && (state != ST_RUN)) ||
                   (is_ack && arg[0] && (state != ST_IDLE));

  assign tick   = (state == ST_RUN) && (presc == PRESC_LAST) && !ctl_disable;
  assign expire = tick && (contador == 8'd0);

  // Command bookkeeping: toggle tracking, reload value and control flags.
  // NOTE: every register here uses <= so all blocks sample the same pre-edge
  // values; in particular a periodic reload on this edge sees the old recarga.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_reg <= 1'b0;
      recarga    <= 8'h00;
      periodic   <= 1'b0;
      irq_en     <= 1'b0;
      view       <= 1'b0;
    end else begin
      if (accept) begin
        toggle_reg <= datoCPU[7];
      end
      if (is_load_lo) begin
        recarga[3:0] <= arg;
      end
      if (is_load_hi) begin
        recarga[7:4] <= arg;
      end
      if (is_control) begin
        periodic <= arg[1];
        irq_en   <= arg[2];
        view     <= arg[3];
      end
    end
  end

  // Pending flag: expiry has priority over an acknowledge on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendiente <= 1'b0;
    end else if (expire) begin
      pendiente <= 1'b1;
    end else if (is_ack) begin
      pendiente <= 1'b0;
    end
  end

  // Timing core: run state, prescaler and down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      contador <= 8'h00;
      presc    <= '0;
    end else if (restart) begin
      contador <= recarga;
      presc    <= '0;
      state    <= ST_RUN;
    end else if (ctl_disable) begin
      // Counter and prescaler freeze; a later enable restarts them anyway.
      state <= ST_IDLE;
    end else if (state == ST_RUN) begin
      if (tick) begin
        presc <= '0;
        if (expire) begin
          if (periodic) begin
            contador <= recarga;
          end else begin
            state <= ST_EXPIRED;
          end
        end else begin
          contador <= contador - 8'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Read-back and interrupt are pure decodes of registers, so reset clears
  // them immediately and no path exists from datoCPU to either output.
  always_comb begin
    datoDispositivo = {toggle_reg, pendiente, state, periodic, irq_en, 2'b00};
    if (view) begin
      datoDispositivo = contador;
    end
  end

  assign interrupcion = pendiente & irq_en;

endmodule
